fetch_db_store_ctrl: RTL and testbench

FETCH_DB_STORE_CTRL -- requirements
Module: fetch_db_store_ctrl

---
 rtl/fetch_db_store_ctrl_if.sv | 35 +++
 rtl/fetch_db_store_ctrl.sv | 179 +++++++++++++++++
 tb/tb_fetch_db_store_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_db_store_ctrl_if.sv
// Bus between the deblock-store controller and the external write port.
// The controller (master) requests a burst, receives a one-cycle grant,
// then reads the deblock buffer and tags the outgoing write beats.
//   ext_req_o         master -> slave  burst request level
//   ext_gnt_i         slave -> master  one-burst grant pulse
//   ext_store_en_o    master -> slave  deblock buffer read enable
//   ext_store_addr_o  master -> slave  word address inside the current buffer
//   ext_wvalid_o      master -> slave  buffer read data valid (en delayed 1)
//   ext_wlast_o       master -> slave  last beat of a burst, aligned to wvalid
interface fetch_db_store_ctrl_if;
  logic       ext_req_o;
  logic       ext_gnt_i;
  logic       ext_store_en_o;
  logic [7:0] ext_store_addr_o;
  logic       ext_wvalid_o;
  logic       ext_wlast_o;

  modport master (
    output ext_req_o,
    input  ext_gnt_i,
    output ext_store_en_o,
    output ext_store_addr_o,
    output ext_wvalid_o,
    output ext_wlast_o
  );

  modport slave (
    input  ext_req_o,
    output ext_gnt_i,
    input  ext_store_en_o,
    input  ext_store_addr_o,
    input  ext_wvalid_o,
    input  ext_wlast_o
  );
endinterface

// File: rtl/fetch_db_store_ctrl.sv
// Drains filled deblock buffers to external memory in fixed-length bursts.
// A counter tracks how many rotating buffers hold a finished LCU; whenever
// one is pending the FSM requests the bus, streams BURST_LEN sequential
// words per grant, and after the final word of the LCU pulses store_done to
// release the buffer.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   db_done_i          deblock finished filling one buffer (pulse)
//   ext                external bus / buffer read port (master modport)
//   ext_store_done_o   current buffer fully read (pulse)
//   ext_store_ready_o  at least one filled buffer pending
//   occ_o              number of filled buffers, 0..NUM_BUF
//   err_ovf_o          sticky: db_done_i arrived with all buffers full
module fetch_db_store_ctrl #(
  parameter int WORDS_PER_LCU = 192,
  parameter int BURST_LEN     = 16,
  parameter int NUM_BUF       = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         db_done_i,
  fetch_db_store_ctrl_if.master        ext,
  output logic                         ext_store_done_o,
  output logic                         ext_store_ready_o,
  output logic [1:0]                   occ_o,
  output logic                         err_ovf_o
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);
  localparam logic [7:0]        LAST_ADDR = 8'(WORDS_PER_LCU - 1);
  localparam logic [1:0]        FULL      = 2'(NUM_BUF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [7:0]          addr;
  logic [BEAT_W-1:0]   beat;
  logic                req;
  logic                store_en;
  logic                done;
  logic                wvalid;
  logic                wlast;
  logic [1:0]          occ;
  logic                err_ovf;

  // Transfer FSM; req/store_en/done are registered alongside the next state
  // so each output is high exactly while the FSM sits in its state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      addr     <= 8'd0;
      beat     <= BEAT_ZERO;
      req      <= 1'b0;
      store_en <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          store_en <= 1'b0;
          done     <= 1'b0;
          if (occ != 2'd0) begin
            state <= REQ;
            req   <= 1'b1;
          end else begin
            state <= IDLE;
            req   <= 1'b0;
          end
        end
        REQ: begin
          done <= 1'b0;
          if (ext.ext_gnt_i) begin
            state    <= BURST;
            req      <= 1'b0;
            store_en <= 1'b1;
            beat     <= BEAT_ZERO;
          end else begin
            state    <= REQ;
            req      <= 1'b1;
            store_en <= 1'b0;
          end
        end
        BURST: begin
          beat <= beat + BEAT_ONE;
          if (beat == LAST_BEAT) begin
            store_en <= 1'b0;
            if (addr == LAST_ADDR) begin
              // Whole LCU read: release the buffer, next LCU starts at 0.
              state <= DONE;
              done  <= 1'b1;
              req   <= 1'b0;
              addr  <= 8'd0;
            end else begin
              state <= REQ;
              done  <= 1'b0;
              req   <= 1'b1;
              addr  <= addr + 8'd1;
            end
          end else begin
            state    <= BURST;
            store_en <= 1'b1;
            req      <= 1'b0;
            done     <= 1'b0;
            addr     <= addr + 8'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          req      <= 1'b0;
          store_en <= 1'b0;
          addr     <= 8'd0;
        end
        default: begin
          state    <= IDLE;
          addr     <= 8'd0;
          beat     <= BEAT_ZERO;
          req      <= 1'b0;
          store_en <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Buffer data arrives one cycle after the read enable, so valid/last lag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wvalid <= 1'b0;
      wlast  <= 1'b0;
    end else begin
      wvalid <= store_en;
      wlast  <= (state == BURST) && (beat == LAST_BEAT);
    end
  end

  // Filled-buffer count; a fill and a release in the same cycle cancel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ     <= 2'd0;
      err_ovf <= 1'b0;
    end else begin
      if (db_done_i && (occ == FULL)) begin
        err_ovf <= 1'b1;
      end else begin
        err_ovf <= err_ovf;
      end
      case ({db_done_i, done})
        2'b10: begin
          if (occ != FULL) begin
            occ <= occ + 2'd1;
          end else begin
            occ <= occ;
          end
        end
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign ext.ext_req_o        = req;
  assign ext.ext_store_en_o   = store_en;
  assign ext.ext_store_addr_o = addr;
  assign ext.ext_wvalid_o     = wvalid;
  assign ext.ext_wlast_o      = wlast;
  assign ext_store_done_o     = done;
  assign ext_store_ready_o    = (occ != 2'd0);
  assign occ_o                = occ;
  assign err_ovf_o            = err_ovf;

endmodule

// File: tb/tb_fetch_db_store_ctrl.sv
// Self-checking bench for fetch_db_store_ctrl: directed scenarios plus a
// randomized phase, every cycle compared against a transaction-level model
// (occupancy arithmetic, expected word stream 0..WORDS-1, burst boundaries
// derived from the word index).
module tb_fetch_db_store_ctrl;
  localparam int WORDS = 192;
  localparam int BL    = 16;
  localparam int NB    = 3;

  logic       clk;
  logic       rstn;
  logic       db_done;
  logic       done;
  logic       ready;
  logic [1:0] occ;
  logic       err;

  fetch_db_store_ctrl_if bus();

  fetch_db_store_ctrl #(
    .WORDS_PER_LCU (WORDS),
    .BURST_LEN     (BL),
    .NUM_BUF       (NB)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .db_done_i         (db_done),
    .ext               (bus),
    .ext_store_done_o  (done),
    .ext_store_ready_o (ready),
    .occ_o             (occ),
    .err_ovf_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  int occ_m;
  bit err_m;
  int next_addr;
  bit p_req, p_en, p_done, p_idle;
  int p_addr;
  bit auto_gnt, rand_gnt;
  int n_wvalid, n_wlast, n_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    occ_m = 0; err_m = 1'b0; next_addr = 0;
    p_req = 1'b0; p_en = 1'b0; p_done = 1'b0; p_idle = 1'b1; p_addr = 0;
  endtask

  task automatic zero_check(input string pfx);
    chk({pfx, "_req"},   bus.ext_req_o, 0);
    chk({pfx, "_en"},    bus.ext_store_en_o, 0);
    chk({pfx, "_addr"},  bus.ext_store_addr_o, 0);
    chk({pfx, "_wv"},    bus.ext_wvalid_o, 0);
    chk({pfx, "_wl"},    bus.ext_wlast_o, 0);
    chk({pfx, "_done"},  done, 0);
    chk({pfx, "_ready"}, ready, 0);
    chk({pfx, "_occ"},   occ, 0);
    chk({pfx, "_err"},   err, 0);
  endtask

  // One clock: inputs already set are sampled at the edge, outputs checked 1 time unit later.
  task automatic cyc();
    bit g, d, e_req, e_en, e_done, e_last, beat_end;
    int occ_old;
    @(posedge clk);
    g = bus.ext_gnt_i;
    d = db_done;
    #1;
    occ_old = occ_m;
    if (d && occ_m == NB) err_m = 1'b1;
    if (d && !p_done && occ_m < NB) occ_m = occ_m + 1;
    else if (!d && p_done) occ_m = occ_m - 1;
    beat_end = p_en && ((p_addr % BL) == BL - 1);
    e_done = p_en && (p_addr == WORDS - 1);
    e_en   = (p_req && g) || (p_en && !beat_end);
    e_req  = (p_req && !g) || (beat_end && p_addr != WORDS - 1) || (p_idle && occ_old != 0);
    e_last = beat_end;
    chk("occ", occ, occ_m);
    chk("err_ovf", err, err_m);
    chk("ready", ready, (occ_m != 0));
    chk("store_done", done, e_done);
    chk("store_en", bus.ext_store_en_o, e_en);
    chk("req", bus.ext_req_o, e_req);
    chk("wvalid", bus.ext_wvalid_o, p_en);
    chk("wlast", bus.ext_wlast_o, e_last);
    if (bus.ext_store_en_o) begin
      chk("addr_seq", bus.ext_store_addr_o, next_addr);
      next_addr = (next_addr + 1) % WORDS;
    end
    if (bus.ext_wvalid_o) n_wvalid++;
    if (bus.ext_wlast_o) n_wlast++;
    if (done) n_done++;
    p_req  = bus.ext_req_o;
    p_en   = bus.ext_store_en_o;
    p_addr = int'(bus.ext_store_addr_o);
    p_done = done;
    p_idle = !bus.ext_req_o && !bus.ext_store_en_o && !done;
    if (rand_gnt) bus.ext_gnt_i = 1'($urandom_range(0, 1));
    else if (auto_gnt) bus.ext_gnt_i = bus.ext_req_o;
  endtask

  task automatic pulse_db();
    db_done = 1'b1;
    cyc();
    db_done = 1'b0;
  endtask

  task automatic drain(input string tag);
    auto_gnt = 1'b1;
    for (int i = 0; i < 3000 && occ != 2'd0; i++) cyc();
    chk(tag, occ, 0);
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b_wv, b_wl, b_dn;
    logic [7:0] held;

    rstn = 1'b0; db_done = 1'b0; bus.ext_gnt_i = 1'b0;
    auto_gnt = 1'b0; rand_gnt = 1'b0;
    n_wvalid = 0; n_wlast = 0; n_done = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 zero_check("rst");
    @(negedge clk) rstn = 1'b1;
    model_reset();
    repeat (3) cyc();

    // Single LCU: 12 bursts, 192 words, one done pulse.
    auto_gnt = 1'b1;
    b_wv = n_wvalid; b_wl = n_wlast; b_dn = n_done;
    pulse_db();
    chk("b_occ1", occ, 1);
    chk("b_req_lat0", bus.ext_req_o, 0);
    cyc();
    chk("b_req_lat1", bus.ext_req_o, 1);
    for (int i = 0; i < 400 && n_done == b_dn; i++) cyc();
    chk("b_done_cnt", n_done - b_dn, 1);
    chk("b_wvalid_cnt", n_wvalid - b_wv, 192);
    chk("b_wlast_cnt", n_wlast - b_wl, 12);
    cyc();
    chk("b_occ0", occ, 0);
    repeat (2) cyc();

    // Fill arriving in the same cycle as a release keeps occupancy.
    auto_gnt = 1'b0;
    pulse_db();
    pulse_db();
    chk("c_occ2", occ, 2);
    auto_gnt = 1'b1;
    for (int i = 0; i < 400 && !done; i++) cyc();
    chk("c_done_seen", done, 1);
    db_done = 1'b1;
    cyc();
    db_done = 1'b0;
    chk("c_occ_hold", occ, 2);
    for (int i = 0; i < 20 && !bus.ext_store_en_o; i++) cyc();
    chk("c_next_en", bus.ext_store_en_o, 1);
    chk("c_next_addr0", bus.ext_store_addr_o, 0);
    drain("c_drain");

    // Overflow: four fills with no grant.
    auto_gnt = 1'b0;
    bus.ext_gnt_i = 1'b0;
    repeat (4) pulse_db();
    chk("d_occ3", occ, 3);
    chk("d_err", err, 1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("d_req_hold", bus.ext_req_o, 1);
    end
    drain("d_drain");
    chk("d_err_sticky", err, 1);

    // Stray grants while idle are ignored.
    auto_gnt = 1'b0;
    bus.ext_gnt_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("e_stray_en", bus.ext_store_en_o, 0);
      chk("e_stray_req", bus.ext_req_o, 0);
    end
    bus.ext_gnt_i = 1'b0;
    // Grant withheld for 50 cycles mid-LCU.
    pulse_db();
    auto_gnt = 1'b1;
    for (int i = 0; i < 100 && bus.ext_store_addr_o != 8'd16; i++) cyc();
    auto_gnt = 1'b0;
    bus.ext_gnt_i = 1'b0;
    chk("e_req_up", bus.ext_req_o, 1);
    held = bus.ext_store_addr_o;
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk("e_stall_req", bus.ext_req_o, 1);
      chk("e_stall_en", bus.ext_store_en_o, 0);
      chk("e_stall_addr", bus.ext_store_addr_o, held);
    end
    drain("e_drain");

    // Asynchronous reset in the middle of a burst.
    auto_gnt = 1'b1;
    pulse_db();
    for (int i = 0; i < 300 && !(bus.ext_store_en_o && bus.ext_store_addr_o == 8'd37); i++) cyc();
    chk("f_at37", bus.ext_store_addr_o, 37);
    #2 rstn = 1'b0;
    #1 zero_check("f_async");
    bus.ext_gnt_i = 1'b0;
    auto_gnt = 1'b0;
    @(negedge clk) rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("f_idle_req", bus.ext_req_o, 0);
      chk("f_idle_done", done, 0);
    end
    auto_gnt = 1'b1;
    pulse_db();
    for (int i = 0; i < 10 && !bus.ext_store_en_o; i++) cyc();
    chk("f_restart_en", bus.ext_store_en_o, 1);
    chk("f_restart_addr", bus.ext_store_addr_o, 0);
    drain("f_drain");

    // Back-to-back: three buffers, continuous grants.
    auto_gnt = 1'b0;
    bus.ext_gnt_i = 1'b0;
    repeat (3) pulse_db();
    b_wv = n_wvalid; b_wl = n_wlast; b_dn = n_done;
    auto_gnt = 1'b1;
    for (int i = 0; i < 2000 && (n_done - b_dn) < 3; i++) cyc();
    chk("g_done_cnt", n_done - b_dn, 3);
    chk("g_wvalid_cnt", n_wvalid - b_wv, 576);
    chk("g_wlast_cnt", n_wlast - b_wl, 36);
    drain("g_drain");

    // Randomized fills and grants (grants also land outside REQ).
    auto_gnt = 1'b0;
    rand_gnt = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      db_done = ($urandom_range(0, 149) == 0);
      cyc();
    end
    db_done = 1'b0;
    rand_gnt = 1'b0;
    drain("h_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
